timer_multi: RTL
================

# timer_multi

Multi-channel, parametrised bus-mapped timer peripheral on the `pclk` fabric bus. It provides NUM_CH independent counters, each with:
- a programmable prescaler;
- overflow (period) and compare match;
- periodic or one-shot mode.

Per-event status is write-1-to-clear, with a global enable mask. All enabled events are OR-reduced onto a single registered `fabint` line to the processor.

## Interface
Parameters:
- NUM_CH, 4, number of timer channels (1..16)
- WIDTH, 32, counter/load/compare width in bits (8..32)

Ports:
- pclk  in  1  bus/system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- bus_write_en  in  1  write strobe, one cycle per access
- bus_read_en  in  1  read strobe, one cycle per access
- bus_addr  in  32  byte address; only [8:2] decoded
- bus_write_data  in  32  write data
- bus_read_data  out  32  registered read data
- fabint  out  1  registered interrupt request, level, active-high

## Operation
- Address decode:
  - bus_addr[8]=0 selects channel registers: channel = bus_addr[7:4], register = bus_addr[3:2].
  - bus_addr[8]=1 selects global registers.
- Channel registers, offset = ch*0x10:
  - 0x0 LOAD (rw): period value. A write also clears COUNT and the prescaler.
  - 0x4 COUNT (r): current count. Any write clears COUNT and the prescaler; write data is ignored.
  - 0x8 CTRL (rw):
    - bit0 EN
    - bit1 ONESHOT
    - bit2 CMP_EN
    - bit3 OVF_EN
    - [15:8] PRESCALE
    - other bits read 0
  - 0xC COMPARE (rw).
- Global registers:
  - 0x100 IRQ_STATUS: bit 2i = channel i overflow, bit 2i+1 = channel i compare. Write-1-to-clear; reads 0 above bit 2*NUM_CH-1.
  - 0x104 IRQ_ENABLE (rw): same bit layout; unimplemented bits read 0.
- Width rules:
  - LOAD/COMPARE/COUNT hold WIDTH bits; writes truncate to [WIDTH-1:0] and reads zero-extend.
  - Prescaler counter is 8 bits.
- Tick generation, per channel while EN=1:
  - The prescaler increments each cycle.
  - When prescaler == PRESCALE, it returns to 0 and a tick occurs. PRESCALE=0 gives a tick every cycle.
- On tick:
  - If COUNT == LOAD: COUNT <- 0. If OVF_EN, set the overflow status bit. If ONESHOT, clear CTRL.EN in the same edge.
  - Else: COUNT <- COUNT+1.
  - Independently, if CMP_EN and COUNT == COMPARE (pre-update value), set the compare status bit. A compare and an overflow on the same tick set both bits.
- EN=0: COUNT and prescaler hold their values. Re-enabling resumes without clearing.
- Status-bit priority: a hardware set and a W1C clear on the same bit in the same cycle resolve to set.
- CTRL write with EN=1 on the same edge that a one-shot would clear EN: the bus write wins.
- Bus priority: a write and a read in the same cycle perform the write only; bus_read_data holds.
- Unmapped reads return 0. Unmapped writes and channel index >= NUM_CH are ignored.
- Reset values: all registers, COUNT, prescalers, IRQ_STATUS, IRQ_ENABLE, bus_read_data and fabint are 0.

## Timing
- Read latency is 1 cycle. bus_read_data updates on the edge where bus_read_en=1 and holds until the next read.
- Register writes take effect at the edge they are sampled; behaviour depending on them starts the following cycle.
- EN written 1 at edge N, PRESCALE=0: COUNT=1 after edge N+1.
- Period is (LOAD+1)*(PRESCALE+1) cycles from overflow to overflow.
- Status bit sets at the tick edge. fabint = |(IRQ_STATUS & IRQ_ENABLE) registered, so it rises one edge after the status set.
- After a W1C of the last pending enabled bit at edge N, fabint falls at edge N+1.
- Reset asserted mid-count clears everything at the next edge, regardless of bus strobes.

## Test plan
- Periodic overflow, PRESCALE=0: ch0 LOAD=4, CTRL=0x9, IRQ_ENABLE=0x1. Required: overflow every 5 cycles; status[0] set when COUNT wraps 4->0; fabint high one cycle later; W1C 0x1 drops fabint next cycle.
- Prescale and compare: ch1 LOAD=9, COMPARE=3, CTRL=0x0305. Required: COUNT advances every 4 cycles; status[3] sets when COUNT=3; status[2] stays 0 (OVF_EN=0).
- One-shot: ch2 LOAD=2, CTRL=0xB. Required: single overflow; CTRL reads 0xA afterwards; COUNT stays 0; no further status sets.
- Collision: W1C of status[0] issued on the same cycle as a new ch0 overflow. Required: status[0] remains 1. Also LOAD=COMPARE=5 with CMP_EN and OVF_EN set: both bits set on the same tick.
- Bus edge cases:
  - LOAD write mid-count: COUNT=0 next cycle.
  - Read ch index >= NUM_CH and 0x108: both return 0.
  - Simultaneous read+write: bus_read_data unchanged.
- Reset mid-operation with fabint=1 and COUNT nonzero: one reset cycle returns all outputs and registers to 0.

Source files
------------

// File: rtl/timer_multi.sv
// Multi-channel bus-mapped timer: per-channel prescaler, period overflow and
// compare match, W1C status with enable mask, OR-reduced onto registered fabint.
module timer_multi #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        bus_write_en,
  input  logic        bus_read_en,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_write_data,
  output logic [31:0] bus_read_data,
  output logic        fabint
);

  localparam int SW = 2 * NUM_CH;

  logic          rd_only;
  logic          glb_status_hit;
  logic          glb_enable_hit;
  logic [SW-1:0] hw_set;
  logic [31:0]   ch_rdata [NUM_CH];
  logic [31:0]   rd_word;

  logic [SW-1:0] irq_status_q, irq_status_d;
  logic [SW-1:0] irq_enable_q, irq_enable_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fabint_q, fabint_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus_addr[31:9], bus_addr[1:0]};

  // A simultaneous write suppresses the read so the read data simply holds.
  assign rd_only        = bus_read_en & ~bus_write_en;
  assign glb_status_hit = bus_addr[8] && (bus_addr[7:2] == 6'd0);
  assign glb_enable_hit = bus_addr[8] && (bus_addr[7:2] == 6'd1);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic [7:0]       presc_q, presc_d;
    logic [7:0]       pcnt_q, pcnt_d;
    logic             en_q, en_d;
    logic             oneshot_q, oneshot_d;
    logic             cmp_en_q, cmp_en_d;
    logic             ovf_en_q, ovf_en_d;
    logic             ch_wr;
    logic             tick;
    logic             wrap;

    assign ch_wr = bus_write_en && !bus_addr[8] && (bus_addr[7:4] == 4'(gi));
    assign tick  = en_q && (pcnt_q == presc_q);
    assign wrap  = tick && (count_q == load_q);

    always_comb begin
      load_d    = load_q;
      count_d   = count_q;
      cmp_d     = cmp_q;
      presc_d   = presc_q;
      pcnt_d    = pcnt_q;
      en_d      = en_q;
      oneshot_d = oneshot_q;
      cmp_en_d  = cmp_en_q;
      ovf_en_d  = ovf_en_q;

      if (en_q) begin
        pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
      end
      if (tick) begin
        count_d = wrap ? '0 : count_q + WIDTH'(1);
      end
      if (wrap && oneshot_q) begin
        en_d = 1'b0;
      end

      // Bus writes come last so they override the counting path.
      if (ch_wr) begin
        case (bus_addr[3:2])
          2'd0: begin
            load_d  = bus_write_data[WIDTH-1:0];
            count_d = '0;
            pcnt_d  = '0;
          end
          2'd1: begin
            count_d = '0;
            pcnt_d  = '0;
          end
          2'd2: begin
            en_d      = bus_write_data[0];
            oneshot_d = bus_write_data[1];
            cmp_en_d  = bus_write_data[2];
            ovf_en_d  = bus_write_data[3];
            presc_d   = bus_write_data[15:8];
          end
          2'd3: cmp_d = bus_write_data[WIDTH-1:0];
        endcase
      end
    end

    always_ff @(posedge pclk) begin
      if (reset) begin
        load_q    <= '0;
        count_q   <= '0;
        cmp_q     <= '0;
        presc_q   <= '0;
        pcnt_q    <= '0;
        en_q      <= 1'b0;
        oneshot_q <= 1'b0;
        cmp_en_q  <= 1'b0;
        ovf_en_q  <= 1'b0;
      end else begin
        load_q    <= load_d;
        count_q   <= count_d;
        cmp_q     <= cmp_d;
        presc_q   <= presc_d;
        pcnt_q    <= pcnt_d;
        en_q      <= en_d;
        oneshot_q <= oneshot_d;
        cmp_en_q  <= cmp_en_d;
        ovf_en_q  <= ovf_en_d;
      end
    end

    assign hw_set[2*gi]   = wrap && ovf_en_q;
    assign hw_set[2*gi+1] = tick && cmp_en_q && (count_q == cmp_q);

    assign ch_rdata[gi] =
      (bus_addr[3:2] == 2'd0) ? 32'(load_q)  :
      (bus_addr[3:2] == 2'd1) ? 32'(count_q) :
      (bus_addr[3:2] == 2'd2) ? {16'd0, presc_q, 4'd0, ovf_en_q, cmp_en_q, oneshot_q, en_q} :
                                32'(cmp_q);
  end

  always_comb begin
    irq_status_d = irq_status_q;
    irq_enable_d = irq_enable_q;
    if (bus_write_en && glb_status_hit) begin
      irq_status_d = irq_status_q & ~bus_write_data[SW-1:0];
    end
    // Hardware events win over a same-cycle clear.
    irq_status_d = irq_status_d | hw_set;
    if (bus_write_en && glb_enable_hit) begin
      irq_enable_d = bus_write_data[SW-1:0];
    end

    fabint_d = |(irq_status_q & irq_enable_q);

    rd_word = 32'd0;
    if (!bus_addr[8]) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (bus_addr[7:4] == 4'(i)) rd_word = ch_rdata[i];
      end
    end else if (glb_status_hit) begin
      rd_word = 32'(irq_status_q);
    end else if (glb_enable_hit) begin
      rd_word = 32'(irq_enable_q);
    end
    rdata_d = rd_only ? rd_word : rdata_q;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      irq_status_q <= '0;
      irq_enable_q <= '0;
      rdata_q      <= '0;
      fabint_q     <= 1'b0;
    end else begin
      irq_status_q <= irq_status_d;
      irq_enable_q <= irq_enable_d;
      rdata_q      <= rdata_d;
      fabint_q     <= fabint_d;
    end
  end

  assign bus_read_data = rdata_q;
  assign fabint        = fabint_q;

endmodule
